// File: rtl/vga_line_buffer_if.sv
// Pixel-side bundle for vga_line_buffer: upstream fill handshake plus driver read/status signals.
interface vga_line_buffer_if #(
  parameter int unsigned PIXEL_BITS = 12
);
  logic                  in_valid;
  logic [PIXEL_BITS-1:0] in_data;
  logic                  in_ready;
  logic                  line_start;
  logic                  pix_req;
  logic [PIXEL_BITS-1:0] pix_data;
  logic                  underrun;
  logic                  underrun_clr;

  // Pixel source and VGA driver side
  modport master (
    output in_valid, in_data, line_start, pix_req, underrun_clr,
    input  in_ready, pix_data, underrun
  );

  // Line buffer side
  modport slave (
    input  in_valid, in_data, line_start, pix_req, underrun_clr,
    output in_ready, pix_data, underrun
  );
endinterface

// File: rtl/vga_line_buffer.sv
// Double-buffered single-line pixel store between a pixel source and the VGA timing driver.
// Banks swap on line_start; an incomplete write bank repeats the previous line and flags underrun.
module vga_line_buffer #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned PIXEL_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  vga_line_buffer_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  wsel;
  logic [CW-1:0]         wcount;
  logic [CW-1:0]         rcount;
  logic                  rvalid;
  logic                  in_ready_q;
  logic                  underrun_q;
  logic [PIXEL_BITS-1:0] pix_data_q;

  logic [PIXEL_BITS-1:0] mem [2][WIDTH];

  logic wr_fire;
  logic last_wr;
  logic full_now;
  logic rd_fire;

  assign wr_fire  = bus.in_valid && in_ready_q;
  assign last_wr  = wr_fire && (wcount == CW'(WIDTH - 1));
  assign full_now = (state_q == FULL) || last_wr;
  assign rd_fire  = !bus.line_start && bus.pix_req && rvalid && (rcount < CW'(WIDTH));

  // Write FSM next state; a completing write concurrent with line_start swaps straight back to FILL
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (bus.line_start && full_now) state_d = FILL;
        else if (last_wr)               state_d = FULL;
      end
      FULL: begin
        if (bus.line_start) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == FILL);
    end
  end

  // Write-side bookkeeping and bank swap
  always_ff @(posedge clk) begin
    if (rst) begin
      wsel       <= 1'b0;
      wcount     <= '0;
      rvalid     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (bus.line_start && full_now) begin
        wsel   <= ~wsel;
        wcount <= '0;
        rvalid <= 1'b1;
      end else if (wr_fire) begin
        wcount <= wcount + CW'(1);
      end

      if (bus.line_start && !full_now) underrun_q <= 1'b1;
      else if (bus.underrun_clr)       underrun_q <= 1'b0;
    end
  end

  // Bank storage: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wsel][wcount[AW-1:0]] <= bus.in_data;
  end

  // Read side: one-cycle latency, zero outside valid active pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      rcount     <= '0;
      pix_data_q <= '0;
    end else if (bus.line_start) begin
      rcount     <= '0;
      pix_data_q <= '0;
    end else if (rd_fire) begin
      rcount     <= rcount + CW'(1);
      pix_data_q <= mem[~wsel][rcount[AW-1:0]];
    end else begin
      pix_data_q <= '0;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.pix_data = pix_data_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Self-checking bench for vga_line_buffer (WIDTH=8) with a scoreboard of expected read pixels.
module tb_vga_line_buffer;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PIXEL_BITS = 12;

  logic clk;
  logic rst;

  vga_line_buffer_if #(.PIXEL_BITS(PIXEL_BITS)) bus ();

  vga_line_buffer #(
    .WIDTH      (WIDTH),
    .PIXEL_BITS (PIXEL_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PIXEL_BITS-1:0] line_q[$];
  logic [PIXEL_BITS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic put_px(input logic [PIXEL_BITS-1:0] d);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!bus.in_ready) check("wr_timeout", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic put_line(input logic [PIXEL_BITS-1:0] base, input int n);
    for (int i = 0; i < n; i++) put_px(base + PIXEL_BITS'(i));
  endtask

  task automatic set_line(input logic [PIXEL_BITS-1:0] base);
    line_q.delete();
    for (int i = 0; i < int'(WIDTH); i++) line_q.push_back(base + PIXEL_BITS'(i));
  endtask

  task automatic pulse_ls();
    bus.line_start = 1'b1;
    step();
    bus.line_start = 1'b0;
  endtask

  // Request n pixels; anything beyond the stored line must read as zero
  task automatic read_px(input int n);
    logic [PIXEL_BITS-1:0] e;
    for (int i = 0; i < n; i++) begin
      bus.pix_req = 1'b1;
      exp_q.push_back((i < line_q.size()) ? line_q[i] : '0);
      step();
      e = exp_q.pop_front();
      check($sformatf("pix%0d", i), 32'(bus.pix_data), 32'(e));
    end
    bus.pix_req = 1'b0;
    step();
    check("pix_idle", 32'(bus.pix_data), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b1;
    bus.in_data      = 12'h5A5;
    bus.line_start   = 1'b0;
    bus.pix_req      = 1'b0;
    bus.underrun_clr = 1'b0;

    // Reset held with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_pix_data", 32'(bus.pix_data), 32'd0);
      check("rst_underrun", 32'(bus.underrun), 32'd0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Fill and read
    put_line(12'h001, 8);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    pulse_ls();
    check("swap_ready", 32'(bus.in_ready), 32'd1);
    check("swap_underrun", 32'(bus.underrun), 32'd0);
    set_line(12'h001);
    read_px(8);

    // Backpressure: a full bank must not take further pixels
    put_line(12'h101, 8);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    pulse_ls();
    set_line(12'h101);
    read_px(8);

    // Underrun: partial line repeats the previous one
    put_line(12'h0A0, 8);
    pulse_ls();
    put_line(12'h0B0, 3);
    pulse_ls();
    check("ur_set", 32'(bus.underrun), 32'd1);
    set_line(12'h0A0);
    read_px(8);
    put_line(12'h0B3, 5);
    pulse_ls();
    check("ur_sticky", 32'(bus.underrun), 32'd1);
    set_line(12'h0B0);
    read_px(8);
    bus.underrun_clr = 1'b1;
    step();
    bus.underrun_clr = 1'b0;
    check("ur_clr", 32'(bus.underrun), 32'd0);

    // line_start in the same cycle as the last write
    put_line(12'h0C0, 7);
    check("sim_ready_pre", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_data    = 12'h0C7;
    bus.line_start = 1'b1;
    step();
    bus.in_valid   = 1'b0;
    bus.line_start = 1'b0;
    check("sim_ready", 32'(bus.in_ready), 32'd1);
    check("sim_underrun", 32'(bus.underrun), 32'd0);
    set_line(12'h0C0);
    read_px(8);

    // Set wins over clear
    bus.underrun_clr = 1'b1;
    bus.line_start   = 1'b1;
    step();
    bus.underrun_clr = 1'b0;
    bus.line_start   = 1'b0;
    check("ur_set_wins", 32'(bus.underrun), 32'd1);
    bus.underrun_clr = 1'b1;
    step();
    bus.underrun_clr = 1'b0;
    check("ur_clr2", 32'(bus.underrun), 32'd0);

    // Over-request: the 9th and 10th pixels read as zero
    put_line(12'h0D0, 8);
    pulse_ls();
    set_line(12'h0D0);
    read_px(10);

    // Mid-line reset discards everything
    put_line(12'h0E0, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_underrun", 32'(bus.underrun), 32'd0);
    step();
    check("mid_rst_ready2", 32'(bus.in_ready), 32'd1);
    pulse_ls();
    check("mid_rst_ur", 32'(bus.underrun), 32'd1);
    line_q.delete();
    read_px(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
